// File: rtl/vga_sync_monitor_if.sv
// VGA pin bundle tapped by the sync monitor.
// Carries the pixel-rate enable together with the sync and colour pins so
// that a generator (master) and the monitor (slave) share one connection.
//   pixel_en   : one-clk pixel-rate strobe
//   vga_h_sync : horizontal sync pin (polarity set by the monitor parameter)
//   vga_v_sync : vertical sync pin
//   vga_r/g/b  : 1-bit colour pins
interface vga_sync_monitor_if;
    logic pixel_en;
    logic vga_h_sync;
    logic vga_v_sync;
    logic vga_r;
    logic vga_g;
    logic vga_b;

    modport master (
        output pixel_en, vga_h_sync, vga_v_sync, vga_r, vga_g, vga_b
    );

    modport slave (
        input  pixel_en, vga_h_sync, vga_v_sync, vga_r, vga_g, vga_b
    );
endinterface

// File: rtl/vga_sync_monitor.sv
// VGA receive-side sync monitor.
// Samples the VGA pins at pixel rate, recovers pixel coordinates, checks line
// and frame lengths, tracks lock (SEARCH -> ALIGN -> LOCKED) and reports the
// number of lit red/green/blue pixels of each complete locked frame.
// Ports:
//   clk         : system clock
//   reset       : asynchronous active-low reset
//   vga         : VGA pin bundle (slave modport), incl. pixel_en
//   RxX, RxY    : recovered visible coordinate, 0 outside visible area
//   rx_visible  : registered sample was visible while LOCKED
//   locked      : monitor is in LOCKED
//   timing_err  : sticky error seen while LOCKED
//   frame_done  : one-clk pulse after a frame's counts are latched
//   *_count     : lit pixels of the last complete locked frame
module vga_sync_monitor #(
    parameter int H_TOTAL         = 800,
    parameter int V_TOTAL         = 525,
    parameter int H_VIS_START     = 144,
    parameter int H_VIS           = 640,
    parameter int V_VIS_START     = 35,
    parameter int V_VIS           = 480,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                reset,
    vga_sync_monitor_if.slave   vga,
    output logic [9:0]          RxX,
    output logic [9:0]          RxY,
    output logic                rx_visible,
    output logic                locked,
    output logic                timing_err,
    output logic                frame_done,
    output logic [18:0]         red_count,
    output logic [18:0]         green_count,
    output logic [18:0]         blue_count
);
    localparam logic        SYNC_POL = (SYNC_ACTIVE_LOW != 0);
    localparam logic [10:0] H_TOT_L  = 11'(H_TOTAL);
    localparam logic [10:0] V_TOT_L  = 11'(V_TOTAL);
    localparam logic [10:0] H_VS_L   = 11'(H_VIS_START);
    localparam logic [10:0] H_VE_L   = 11'(H_VIS_START + H_VIS);
    localparam logic [10:0] V_VS_L   = 11'(V_VIS_START);
    localparam logic [10:0] V_VE_L   = 11'(V_VIS_START + V_VIS);
    localparam logic [9:0]  CNT_MAX  = 10'h3FF;
    localparam logic [18:0] ACC_MAX  = 19'h7FFFF;

    typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

    state_t      state, next_state;
    logic [9:0]  hcnt, vcnt, hpos, vpos;
    logic        hs, vs, hs_d, vs_d, hs_rise, vs_rise;
    logic        vs_pend, sof, align_bad;
    logic        vis, line_err, frame_err, latch;
    logic [18:0] red_acc, green_acc, blue_acc;

    // hs/vs are 1 while a pulse is asserted, whatever the pin polarity.
    assign hs      = vga.vga_h_sync ^ SYNC_POL;
    assign vs      = vga.vga_v_sync ^ SYNC_POL;
    assign hs_rise = vga.pixel_en & hs & ~hs_d;
    assign vs_rise = vga.pixel_en & vs & ~vs_d;

    // A vsync start of frame is the first hsync edge at or after the vsync
    // edge, so the frame always begins at the start of a line.
    assign sof = hs_rise & (vs_rise | vs_pend);

    // hcnt/vcnt hold the position of the previous sample; hpos/vpos are the
    // position of the sample being taken now (the hsync edge sample is x=0).
    assign hpos = hs_rise ? 10'd0 : ((hcnt == CNT_MAX) ? CNT_MAX : hcnt + 10'd1);
    assign vpos = sof ? 10'd0 :
                  (hs_rise ? ((vcnt == CNT_MAX) ? CNT_MAX : vcnt + 10'd1) : vcnt);

    assign vis = ({1'b0, hpos} >= H_VS_L) && ({1'b0, hpos} < H_VE_L) &&
                 ({1'b0, vpos} >= V_VS_L) && ({1'b0, vpos} < V_VE_L);

    // A line closes on an hsync edge; running into saturation without an
    // edge is also a line-length error.
    assign line_err  = vga.pixel_en &
                       (hs_rise ? (({1'b0, hcnt} + 11'd1) != H_TOT_L) : (hcnt == CNT_MAX));
    assign frame_err = sof & (({1'b0, vcnt} + 11'd1) != V_TOT_L);

    assign locked = (state == LOCKED);

    // Lock state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= SEARCH;
        else        state <= next_state;
    end

    // Lock transitions; latch marks a clean start of frame while LOCKED.
    always_comb begin
        next_state = state;
        latch      = 1'b0;
        case (state)
            SEARCH: if (sof) next_state = ALIGN;
            ALIGN:  if (sof && !align_bad && !line_err && !frame_err) next_state = LOCKED;
            LOCKED: begin
                if (line_err || frame_err) next_state = SEARCH;
                else if (sof)              latch = 1'b1;
            end
            default: next_state = SEARCH;
        endcase
    end

    // Sync history, position counters and the ALIGN-frame error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_d      <= 1'b0;
            vs_d      <= 1'b0;
            hcnt      <= 10'd0;
            vcnt      <= 10'd0;
            vs_pend   <= 1'b0;
            align_bad <= 1'b0;
        end else if (vga.pixel_en) begin
            hs_d <= hs;
            vs_d <= vs;
            hcnt <= hpos;
            vcnt <= vpos;
            if (sof)          vs_pend <= 1'b0;
            else if (vs_rise) vs_pend <= 1'b1;
            if (sof)                              align_bad <= 1'b0;
            else if (state == ALIGN && line_err)  align_bad <= 1'b1;
        end
    end

    // Coordinate outputs, sticky error and per-frame count latch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RxX         <= 10'd0;
            RxY         <= 10'd0;
            rx_visible  <= 1'b0;
            timing_err  <= 1'b0;
            frame_done  <= 1'b0;
            red_count   <= 19'd0;
            green_count <= 19'd0;
            blue_count  <= 19'd0;
        end else begin
            frame_done <= latch;
            if (locked && (line_err || frame_err)) timing_err <= 1'b1;
            if (vga.pixel_en) begin
                rx_visible <= vis && locked;
                RxX        <= (vis && locked) ? hpos - H_VS_L[9:0] : 10'd0;
                RxY        <= (vis && locked) ? vpos - V_VS_L[9:0] : 10'd0;
            end
            if (latch) begin
                red_count   <= red_acc;
                green_count <= green_acc;
                blue_count  <= blue_acc;
            end
        end
    end

    // Lit-pixel accumulators; every start of frame clears them, after the
    // latch above has taken their value when the frame was clean.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            red_acc   <= 19'd0;
            green_acc <= 19'd0;
            blue_acc  <= 19'd0;
        end else if (vga.pixel_en) begin
            if (sof) begin
                red_acc   <= 19'd0;
                green_acc <= 19'd0;
                blue_acc  <= 19'd0;
            end else if (vis && locked) begin
                if (vga.vga_r && red_acc   != ACC_MAX) red_acc   <= red_acc   + 19'd1;
                if (vga.vga_g && green_acc != ACC_MAX) green_acc <= green_acc + 19'd1;
                if (vga.vga_b && blue_acc  != ACC_MAX) blue_acc  <= blue_acc  + 19'd1;
            end
        end
    end
endmodule

// File: tb/tb_vga_sync_monitor.sv
// Testbench for vga_sync_monitor.
// Two monitors run side by side on a reduced 32x16 timing: one with
// active-low sync pins, one with active-high parameter fed inverted syncs.
// Expected frame counts are queued before each frame and popped whenever a
// monitor pulses frame_done; lock/error/coordinate values are checked inline.
module tb_vga_sync_monitor;
    localparam int H_T = 32;
    localparam int V_T = 16;
    localparam int HVS = 6;
    localparam int HV  = 20;
    localparam int VVS = 3;
    localparam int VV  = 10;

    typedef struct {
        logic [18:0] r;
        logic [18:0] g;
        logic [18:0] b;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t q_n[$];
    exp_t q_p[$];

    vga_sync_monitor_if bus();
    vga_sync_monitor_if bus_p();

    logic [9:0]  rx_x_n, rx_y_n, rx_x_p, rx_y_p;
    logic        vis_n, lock_n, err_n, done_n, vis_p, lock_p, err_p, done_p;
    logic [18:0] r_n, g_n, b_n, r_p, g_p, b_p;

    always #5 clk = ~clk;

    // The second monitor sees the same pins with inverted sync polarity.
    assign bus_p.pixel_en   = bus.pixel_en;
    assign bus_p.vga_h_sync = ~bus.vga_h_sync;
    assign bus_p.vga_v_sync = ~bus.vga_v_sync;
    assign bus_p.vga_r      = bus.vga_r;
    assign bus_p.vga_g      = bus.vga_g;
    assign bus_p.vga_b      = bus.vga_b;

    vga_sync_monitor #(.H_TOTAL(H_T), .V_TOTAL(V_T), .H_VIS_START(HVS), .H_VIS(HV),
                       .V_VIS_START(VVS), .V_VIS(VV), .SYNC_ACTIVE_LOW(1)) dut (
        .clk(clk), .reset(reset), .vga(bus.slave),
        .RxX(rx_x_n), .RxY(rx_y_n), .rx_visible(vis_n), .locked(lock_n),
        .timing_err(err_n), .frame_done(done_n),
        .red_count(r_n), .green_count(g_n), .blue_count(b_n)
    );

    vga_sync_monitor #(.H_TOTAL(H_T), .V_TOTAL(V_T), .H_VIS_START(HVS), .H_VIS(HV),
                       .V_VIS_START(VVS), .V_VIS(VV), .SYNC_ACTIVE_LOW(0)) dut_p (
        .clk(clk), .reset(reset), .vga(bus_p.slave),
        .RxX(rx_x_p), .RxY(rx_y_p), .rx_visible(vis_p), .locked(lock_p),
        .timing_err(err_p), .frame_done(done_p),
        .red_count(r_p), .green_count(g_p), .blue_count(b_p)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int r, input int g, input int b);
        exp_t e;
        e.r = 19'(r);
        e.g = 19'(g);
        e.b = 19'(b);
        q_n.push_back(e);
        q_p.push_back(e);
    endtask

    // Scoreboard for the active-low monitor.
    always @(negedge clk) begin : mon_n
        exp_t e;
        if (done_n === 1'b1) begin
            if (q_n.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL frame_done_n: got unexpected pulse, expected none");
            end else begin
                e = q_n.pop_front();
                check_output("red_count_n", 32'(r_n), 32'(e.r));
                check_output("green_count_n", 32'(g_n), 32'(e.g));
                check_output("blue_count_n", 32'(b_n), 32'(e.b));
            end
        end
    end

    // Scoreboard for the active-high-parameter monitor.
    always @(negedge clk) begin : mon_p
        exp_t e;
        if (done_p === 1'b1) begin
            if (q_p.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL frame_done_p: got unexpected pulse, expected none");
            end else begin
                e = q_p.pop_front();
                check_output("red_count_p", 32'(r_p), 32'(e.r));
                check_output("green_count_p", 32'(g_p), 32'(e.g));
                check_output("blue_count_p", 32'(b_p), 32'(e.b));
            end
        end
    end

    // Pixel pattern: blanking area is always fully lit (must never count).
    // mode 1: green at x 10..14; mode 2: red where x+y even, blue at x 0.
    function automatic logic [2:0] pix(input int h, input int v, input int mode);
        int x, y;
        x = h - HVS;
        y = v - VVS;
        if (h < HVS || h >= HVS + HV || v < VVS || v >= VVS + VV) return 3'b111;
        if (mode == 1) return {1'b0, (x >= 10 && x <= 14), 1'b0};
        if (mode == 2) return {((x + y) % 2 == 0), 1'b0, (x == 0)};
        return 3'b000;
    endfunction

    // One pixel_en tick, one clk wide, every 4th clk.
    task automatic apply_stimulus(input logic hsp, input logic vsp, input logic [2:0] rgb);
        @(negedge clk);
        bus.pixel_en   = 1'b1;
        bus.vga_h_sync = hsp;
        bus.vga_v_sync = vsp;
        {bus.vga_r, bus.vga_g, bus.vga_b} = rgb;
        @(negedge clk);
        bus.pixel_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_both_lock(input string name, input logic exp_lock, input logic exp_err);
        check_output({name, "_locked_n"}, 32'(lock_n), 32'(exp_lock));
        check_output({name, "_locked_p"}, 32'(lock_p), 32'(exp_lock));
        check_output({name, "_err_n"}, 32'(err_n), 32'(exp_err));
        check_output({name, "_err_p"}, 32'(err_p), 32'(exp_err));
    endtask

    task automatic check_rx(input string name, input int x, input int y, input logic v);
        check_output({name, "_RxX_n"}, 32'(rx_x_n), 32'(x));
        check_output({name, "_RxY_n"}, 32'(rx_y_n), 32'(y));
        check_output({name, "_vis_n"}, 32'(vis_n), 32'(v));
        check_output({name, "_RxX_p"}, 32'(rx_x_p), 32'(x));
        check_output({name, "_vis_p"}, 32'(vis_p), 32'(v));
    endtask

    // Drive a frame of 'lines' lines; line 'short_line' is one tick short.
    task automatic run_frame(input int lines, input int short_line, input int mode, input bit chk);
        for (int v = 0; v < lines; v++) begin
            int len;
            len = (v == short_line) ? H_T - 1 : H_T;
            for (int h = 0; h < len; h++) begin
                apply_stimulus((h < 4) ? 1'b0 : 1'b1, (v < 2) ? 1'b0 : 1'b1, pix(h, v, mode));
                if (chk) begin
                    if (v == VVS + 2 && h == HVS + 10) check_rx("first_lit", 10, 2, 1'b1);
                    if (v == VVS + 2 && h == 2)        check_rx("hblank", 0, 0, 1'b0);
                    if (v == VVS && h == HVS + HV - 1) check_rx("last_x", HV - 1, 0, 1'b1);
                    if (v == VVS + VV - 1 && h == HVS) check_rx("last_y", 0, VV - 1, 1'b1);
                    if (v == VVS + VV && h == HVS)     check_rx("vblank", 0, 0, 1'b0);
                end
                if (short_line >= 0 && v == short_line + 1 && h == 0)
                    check_both_lock("after_short_line", 1'b0, 1'b1);
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check_output({name, "_RxX"}, 32'(rx_x_n), 0);
        check_output({name, "_RxY"}, 32'(rx_y_n), 0);
        check_output({name, "_vis"}, 32'(vis_n), 0);
        check_output({name, "_done"}, 32'(done_n), 0);
        check_output({name, "_red"}, 32'(r_n), 0);
        check_output({name, "_green"}, 32'(g_n), 0);
        check_output({name, "_blue"}, 32'(b_n), 0);
        check_output({name, "_green_p"}, 32'(g_p), 0);
        check_both_lock(name, 1'b0, 1'b0);
    endtask

    task automatic pulse_reset(input string name);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs(name);
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset          = 1'b0;
        bus.pixel_en   = 1'b0;
        bus.vga_h_sync = 1'b1;
        bus.vga_v_sync = 1'b1;
        bus.vga_r      = 1'b0;
        bus.vga_g      = 1'b0;
        bus.vga_b      = 1'b0;
        #1;
        check_reset_outputs("power_on");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Nominal lock: ALIGN after the first start of frame, LOCKED after the second.
        run_frame(V_T, -1, 0, 1'b0);
        check_both_lock("align_frame", 1'b0, 1'b0);
        push_exp(0, 50, 0);
        run_frame(V_T, -1, 1, 1'b1);
        check_both_lock("first_locked", 1'b1, 1'b0);
        push_exp(100, 0, 10);
        run_frame(V_T, -1, 2, 1'b0);
        push_exp(0, 50, 0);
        run_frame(V_T, -1, 1, 1'b0);
        run_frame(8, -1, 0, 1'b0);
        check_both_lock("still_locked", 1'b1, 1'b0);

        // Reset mid-frame while LOCKED, then relock.
        pulse_reset("mid_frame_reset");
        run_frame(V_T, -1, 0, 1'b0);
        check_both_lock("relock_align", 1'b0, 1'b0);
        push_exp(0, 50, 0);
        run_frame(V_T, -1, 1, 1'b0);
        check_both_lock("relocked", 1'b1, 1'b0);

        // Short line while LOCKED: error, drop to SEARCH, no frame_done.
        run_frame(V_T, 5, 0, 1'b0);
        check_both_lock("line_err_frame", 1'b0, 1'b1);
        run_frame(V_T, -1, 1, 1'b0);
        check_both_lock("line_err_align", 1'b0, 1'b1);
        push_exp(100, 0, 10);
        run_frame(V_T, -1, 2, 1'b0);
        check_both_lock("line_err_relock", 1'b1, 1'b1);
        push_exp(0, 0, 0);
        run_frame(V_T, -1, 0, 1'b0);
        run_frame(2, -1, 0, 1'b0);

        // Short frame in ALIGN: stays ALIGN without timing_err.
        pulse_reset("clear_err_reset");
        run_frame(V_T - 1, -1, 1, 1'b0);
        check_both_lock("short_frame", 1'b0, 1'b0);
        run_frame(V_T, -1, 1, 1'b0);
        check_both_lock("after_short_frame", 1'b0, 1'b0);
        push_exp(0, 50, 0);
        run_frame(V_T, -1, 1, 1'b0);
        check_both_lock("short_frame_relock", 1'b1, 1'b0);
        run_frame(2, -1, 0, 1'b0);
        repeat (8) @(negedge clk);

        check_output("pending_frames_n", 32'(q_n.size()), 0);
        check_output("pending_frames_p", 32'(q_p.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
